// File: rtl/seq101_pkg.sv
// rtl/seq101_pkg.sv - shared types and constants for the 1-0-1 serial pattern detector
//
// Purpose : state encoding, the fixed pattern and a small decode helper used by
//           the detector top and its next-state sub-module.
// Ports   : none (package).
// Config  : SEQ101_MEALY_EN is not referenced here; see seq101_detector.sv.

package seq101_pkg;

    // Progress through the pattern: how many leading bits of "101" have been seen.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2,
        S_101  = 2'd3
    } seq101_state_t;

    // Bit 2 is the first bit received, bit 0 the last.
    localparam logic [2:0] SEQ101_PATTERN = 3'b101;

    // A complete match is exactly the terminal state; decoding it straight from
    // the state register keeps the registered flag free of input-driven glitches.
    function automatic logic seq101_is_match(input seq101_state_t state);
        return (state == S_101);
    endfunction

endpackage : seq101_pkg

// File: rtl/seq101_if.sv
// rtl/seq101_if.sv - serial bit in / match flags out bundle for the 1-0-1 detector
//
// Purpose : groups the serial stream and the match flags so producer and
//           detector connect through one port.
// Signals : w       - serial data bit, sampled on each rising clk edge
//           z       - registered (Moore) match flag
//           z_mealy - combinational early match flag (only with SEQ101_MEALY_EN)
// Modports: master - drives w, observes the flags (stream source / monitor)
//           slave  - receives w, drives the flags (the detector)
// Config  : SEQ101_MEALY_EN adds z_mealy.

interface seq101_if;

    logic w;
    logic z;
`ifdef SEQ101_MEALY_EN
    logic z_mealy;
`endif

`ifdef SEQ101_MEALY_EN
    modport master (
        output w,
        input  z,
        input  z_mealy
    );

    modport slave (
        input  w,
        output z,
        output z_mealy
    );
`else
    modport master (
        output w,
        input  z
    );

    modport slave (
        input  w,
        output z
    );
`endif

endinterface : seq101_if

// File: rtl/seq101_next_state.sv
// rtl/seq101_next_state.sv - combinational next-state and early-hit logic for the 1-0-1 detector
//
// Purpose : given the current pattern progress and the incoming bit, compute the
//           progress after the next clock edge and whether this bit completes
//           the pattern right now.
// Ports   : state      in  2  current state (seq101_state_t)
//           w          in  1  incoming serial bit
//           next_state out 2  state to load on the next rising edge
//           mealy_hit  out 1  high while state is S_10 and w is the final '1'
// Config  : always built; the top only exposes mealy_hit with SEQ101_MEALY_EN.

import seq101_pkg::*;

module seq101_next_state (
    input  seq101_state_t state,
    input  logic          w,
    output seq101_state_t next_state,
    output logic          mealy_hit
);

    always_comb begin
        next_state = S_IDLE;
        mealy_hit  = 1'b0;

        case (state)
            S_IDLE: begin
                if (w == SEQ101_PATTERN[2]) begin
                    next_state = S_1;
                end else begin
                    next_state = S_IDLE;
                end
            end

            // A repeated '1' is still a valid one-bit prefix, so runs of 1s park here.
            S_1: begin
                if (w == SEQ101_PATTERN[1]) begin
                    next_state = S_10;
                end else begin
                    next_state = S_1;
                end
            end

            // "100" shares no prefix with "101", so a second 0 drops all progress.
            S_10: begin
                if (w == SEQ101_PATTERN[0]) begin
                    next_state = S_101;
                    mealy_hit  = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end

            // Overlap: the trailing '1' of a match is reused as the first bit of
            // the next candidate, so "10101" reports twice.
            S_101: begin
                if (w == SEQ101_PATTERN[1]) begin
                    next_state = S_10;
                end else begin
                    next_state = S_1;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule : seq101_next_state

// File: rtl/seq101_detector.sv
// rtl/seq101_detector.sv - serial 1-0-1 pattern detector with overlap (framing/marker detect)
//
// Purpose : watches a 1-bit stream sampled on each rising clk edge and flags
//           every occurrence of 1-0-1, overlapping occurrences included.
// Ports   : clk      in   1  rising-edge clock, single domain
//           rst      in   1  synchronous, active-high reset (priority over w)
//           bus      slave    seq101_if:
//                               w       in  serial data bit
//                               z       out registered match flag, high the cycle
//                                           after the edge sampling the final '1'
//                               z_mealy out combinational early flag, high during
//                                           the cycle the final '1' is present
// Config  : SEQ101_MEALY_EN - when defined, z_mealy exists and is driven;
//           when undefined it is absent. z behaves identically either way.

import seq101_pkg::*;

module seq101_detector (
    input  logic     clk,
    input  logic     rst,
    seq101_if.slave  bus
);

    seq101_state_t state_q;
    seq101_state_t state_d;
    logic          mealy_hit;

    seq101_next_state u_next_state (
        .state      (state_q),
        .w          (bus.w),
        .next_state (state_d),
        .mealy_hit  (mealy_hit)
    );

    // Reset wins over w on the same edge, so a pattern completed on a reset
    // edge is discarded along with any partial progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.z = seq101_is_match(state_q);

`ifdef SEQ101_MEALY_EN
    // Gated with rst so the early flag never announces a match that the
    // coming reset edge is about to throw away.
    assign bus.z_mealy = mealy_hit & ~rst;
`else
    logic unused_mealy_hit;
    assign unused_mealy_hit = mealy_hit;
`endif

endmodule : seq101_detector

// File: tb/tb_seq101_detector.sv
// tb/tb_seq101_detector.sv - directed self-checking bench for seq101_detector

module tb_seq101_detector;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    seq101_if bus ();

    seq101_detector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive rst/w at the falling edge, then sample 1 time unit later: z shows the
    // state loaded by the previous rising edge, z_mealy reacts to the new w.
    task automatic step(input string tag, input logic r, input logic wv,
                        input logic exp_z, input logic exp_m);
        @(negedge clk);
        rst   = r;
        bus.w = wv;
        #1;
        vectors++;
        assert (bus.z === exp_z)
        else begin
            miscompares++;
            $error("FAIL %s z observed=%0b expected=%0b", tag, bus.z, exp_z);
        end
`ifdef SEQ101_MEALY_EN
        vectors++;
        assert (bus.z_mealy === exp_m)
        else begin
            miscompares++;
            $error("FAIL %s z_mealy observed=%0b expected=%0b", tag, bus.z_mealy, exp_m);
        end
`else
        if (exp_m === 1'bx) begin
            $display("note: %s has undefined mealy expectation", tag);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.w       = 1'b0;
        @(posedge clk);

        // reset held for two cycles, w=0
        step("rst_a",      1'b1, 1'b0, 1'b0, 1'b0);
        step("rst_b",      1'b1, 1'b0, 1'b0, 1'b0);

        // basic hit 1,0,1 -> z only in the 4th cycle
        step("basic_1",    1'b0, 1'b1, 1'b0, 1'b0);
        step("basic_0",    1'b0, 1'b0, 1'b0, 1'b0);
        step("basic_1b",   1'b0, 1'b1, 1'b0, 1'b1);
        step("basic_hit",  1'b0, 1'b0, 1'b1, 1'b0);
        step("basic_post", 1'b0, 1'b0, 1'b0, 1'b0);
        step("basic_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // overlap 1,0,1,0,1 -> z in cycles 4 and 6
        step("ovl_c1",     1'b0, 1'b1, 1'b0, 1'b0);
        step("ovl_c2",     1'b0, 1'b0, 1'b0, 1'b0);
        step("ovl_c3",     1'b0, 1'b1, 1'b0, 1'b1);
        step("ovl_c4",     1'b0, 1'b0, 1'b1, 1'b0);
        step("ovl_c5",     1'b0, 1'b1, 1'b0, 1'b1);
        step("ovl_c6",     1'b0, 1'b0, 1'b1, 1'b0);
        step("ovl_c7",     1'b0, 1'b0, 1'b0, 1'b0);

        // 1,1,0,1 -> one pulse
        step("run_c1",     1'b0, 1'b1, 1'b0, 1'b0);
        step("run_c2",     1'b0, 1'b1, 1'b0, 1'b0);
        step("run_c3",     1'b0, 1'b0, 1'b0, 1'b0);
        step("run_c4",     1'b0, 1'b1, 1'b0, 1'b1);
        step("run_hit",    1'b0, 1'b0, 1'b1, 1'b0);
        step("run_post",   1'b0, 1'b0, 1'b0, 1'b0);

        // 1,0,0,1 -> no match
        step("n1001_c1",   1'b0, 1'b1, 1'b0, 1'b0);
        step("n1001_c2",   1'b0, 1'b0, 1'b0, 1'b0);
        step("n1001_c3",   1'b0, 1'b0, 1'b0, 1'b0);
        step("n1001_c4",   1'b0, 1'b1, 1'b0, 1'b0);
        step("n1001_c5",   1'b0, 1'b0, 1'b0, 1'b0);
        step("n1001_c6",   1'b0, 1'b0, 1'b0, 1'b0);

        // 0,1,1,0 -> no match
        step("n0110_c1",   1'b0, 1'b0, 1'b0, 1'b0);
        step("n0110_c2",   1'b0, 1'b1, 1'b0, 1'b0);
        step("n0110_c3",   1'b0, 1'b1, 1'b0, 1'b0);
        step("n0110_c4",   1'b0, 1'b0, 1'b0, 1'b0);
        step("n0110_c5",   1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-pattern: 1,0 then rst with w=1, then 0,1 -> no match
        step("mid_c1",     1'b0, 1'b1, 1'b0, 1'b0);
        step("mid_c2",     1'b0, 1'b0, 1'b0, 1'b0);
        step("mid_rst",    1'b1, 1'b1, 1'b0, 1'b0);
        step("mid_c4",     1'b0, 1'b0, 1'b0, 1'b0);
        step("mid_c5",     1'b0, 1'b1, 1'b0, 1'b0);
        step("mid_c6",     1'b0, 1'b0, 1'b0, 1'b0);
        step("mid_c7",     1'b0, 1'b0, 1'b0, 1'b0);

        // reset priority on the completing edge
        step("pri_c1",     1'b0, 1'b1, 1'b0, 1'b0);
        step("pri_c2",     1'b0, 1'b0, 1'b0, 1'b0);
        step("pri_rst",    1'b1, 1'b1, 1'b0, 1'b0);
        step("pri_after",  1'b0, 1'b0, 1'b0, 1'b0);
        step("pri_after2", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seq101_detector
